// File: rtl/axi_mem_endpoint.sv
// AXI4 memory slave used as the default target behind one mesh node.
// Register-array backing store with independent write and read engines,
// one outstanding INCR burst per direction, up to 256 beats per burst.

package axi_mem_pkg;

  localparam int AXI_ADDR_W = 16;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_IDW_W  = 4;
  localparam int AXI_IDR_W  = 4;

  // Requests delivered by the mesh (AW/W/AR channels plus B/R ready).
  // AxSIZE/AxBURST are not carried: every burst is full-width INCR.
  typedef struct packed {
    logic [AXI_IDW_W-1:0]    aw_id;
    logic [AXI_ADDR_W-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic                    aw_valid;
    logic [AXI_DATA_W-1:0]   w_data;
    logic [AXI_DATA_W/8-1:0] w_strb;
    logic                    w_last;
    logic                    w_valid;
    logic                    b_ready;
    logic [AXI_IDR_W-1:0]    ar_id;
    logic [AXI_ADDR_W-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic                    ar_valid;
    logic                    r_ready;
  } axi_mosi_t;

  // Responses returned into the mesh.
  typedef struct packed {
    logic                    aw_ready;
    logic                    w_ready;
    logic [AXI_IDW_W-1:0]    b_id;
    logic [1:0]              b_resp;
    logic                    b_valid;
    logic                    ar_ready;
    logic [AXI_IDR_W-1:0]    r_id;
    logic [AXI_DATA_W-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
    logic                    r_valid;
  } axi_miso_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

module axi_mem_endpoint
  import axi_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = AXI_ADDR_W,
  parameter int DATA_WIDTH = AXI_DATA_W,
  parameter int ID_W_WIDTH = AXI_IDW_W,
  parameter int ID_R_WIDTH = AXI_IDR_W,
  parameter int MEM_DEPTH  = 256
) (
  input  logic      ACLK,
  input  logic      ARESETn,
  input  axi_mosi_t s_axi_i,
  output axi_miso_t s_axi_o
);

  localparam int NB     = DATA_WIDTH / 8;
  localparam int OFFS   = $clog2(NB);
  localparam int MEM_AW = $clog2(MEM_DEPTH);
  localparam logic [31:0]           DEPTH_U = 32'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_INC = ADDR_WIDTH'(NB);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return 32'(a >> OFFS) < DEPTH_U;
  endfunction

  function automatic logic [MEM_AW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return MEM_AW'(a >> OFFS);
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  w_state_e w_state, w_state_nxt;
  r_state_e r_state, r_state_nxt;

  logic [ID_W_WIDTH-1:0] w_id;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len, w_cnt;
  logic                  w_err;

  logic [ID_R_WIDTH-1:0] r_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len, r_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_err;

  logic aw_ready, w_ready, b_valid, ar_ready, r_valid;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic w_final, r_final, w_in_range;
  logic                  r_load;
  logic [ADDR_WIDTH-1:0] r_load_addr;

  assign aw_hs       = s_axi_i.aw_valid & aw_ready;
  assign w_hs        = s_axi_i.w_valid  & w_ready;
  assign b_hs        = b_valid & s_axi_i.b_ready;
  assign ar_hs       = s_axi_i.ar_valid & ar_ready;
  assign r_hs        = r_valid & s_axi_i.r_ready;
  assign w_final     = (w_cnt == w_len);
  assign r_final     = (r_cnt == r_len);
  assign w_in_range  = in_range(w_addr);
  assign r_load      = ar_hs | (r_hs & ~r_final);
  assign r_load_addr = ar_hs ? s_axi_i.ar_addr : r_addr + ADDR_INC;

  // State registers for both engines.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;
    end
  end

  // Next-state logic: a burst ends on its final beat or on an early WLAST.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_state_nxt = w_state;
    r_state_nxt = r_state;
    unique case (w_state)
      W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
      W_DATA:  if (w_hs && (w_final || s_axi_i.w_last)) w_state_nxt = W_RESP;
      W_RESP:  if (b_hs) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
    unique case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
      R_DATA:  if (r_hs && r_final) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Outputs decoded from state; readies are held low while reset is asserted.
  always_comb begin
    aw_ready = ARESETn && (w_state == W_IDLE);
    w_ready  = ARESETn && (w_state == W_DATA);
    b_valid  = (w_state == W_RESP);
    ar_ready = ARESETn && (r_state == R_IDLE);
    r_valid  = (r_state == R_DATA);

    s_axi_o          = '0;
    s_axi_o.aw_ready = aw_ready;
    s_axi_o.w_ready  = w_ready;
    s_axi_o.b_valid  = b_valid;
    s_axi_o.b_id     = w_id;
    s_axi_o.b_resp   = (b_valid && w_err) ? RESP_SLVERR : RESP_OKAY;
    s_axi_o.ar_ready = ar_ready;
    s_axi_o.r_valid  = r_valid;
    s_axi_o.r_id     = r_id;
    s_axi_o.r_data   = r_data;
    s_axi_o.r_resp   = (r_valid && r_err) ? RESP_SLVERR : RESP_OKAY;
    s_axi_o.r_last   = r_valid && r_final;
  end

  // Write burst bookkeeping: address, beat count and sticky error.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      w_id   <= '0;
      w_addr <= '0;
      w_len  <= '0;
      w_cnt  <= '0;
      w_err  <= 1'b0;
    end else if (aw_hs) begin
      w_id   <= s_axi_i.aw_id;
      w_addr <= s_axi_i.aw_addr;
      w_len  <= s_axi_i.aw_len;
      w_cnt  <= '0;
      w_err  <= 1'b0;
    end else if (w_hs) begin
      w_addr <= w_addr + ADDR_INC;
      w_cnt  <= w_cnt + 8'd1;
      w_err  <= w_err | ~w_in_range | (s_axi_i.w_last ^ w_final);
    end
  end

  // Byte-lane writes into the backing store.
  always_ff @(posedge ACLK) begin
    // NOTE: the array has no reset; its contents survive ARESETn by design.
    if (w_hs && w_in_range) begin
      for (int k = 0; k < NB; k++) begin
        if (s_axi_i.w_strb[k]) mem[word_idx(w_addr)][8*k +: 8] <= s_axi_i.w_data[8*k +: 8];
      end
    end
  end

  // Read burst: fetch the first word on AR, the next word on each accepted beat.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_id   <= '0;
      r_addr <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
    end else begin
      if (ar_hs) begin
        r_id  <= s_axi_i.ar_id;
        r_len <= s_axi_i.ar_len;
        r_cnt <= '0;
      end else if (r_hs && !r_final) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (r_load) begin
        // NOTE: non-blocking update means a same-edge write is not seen here; reads return old data.
        r_addr <= r_load_addr;
        r_data <= in_range(r_load_addr) ? mem[word_idx(r_load_addr)] : '0;
        r_err  <= ~in_range(r_load_addr);
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_endpoint.sv
// Directed bench for axi_mem_endpoint. Expected B/R responses are queued when
// a burst is issued; a negedge monitor pops and compares on each handshake and
// checks payload stability while the master applies backpressure.

module tb_axi_mem_endpoint;
  import axi_mem_pkg::*;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } b_exp_t;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;

  logic      ACLK = 1'b0;
  logic      ARESETn;
  axi_mosi_t drv;
  axi_mosi_t port_in;
  axi_miso_t port_out;
  logic      rr = 1'b1;
  bit        r_toggle = 1'b0;

  int checks = 0;
  int fails  = 0;

  b_exp_t b_q[$];
  r_exp_t r_q[$];

  always #5 ACLK = ~ACLK;

  always_comb begin
    port_in         = drv;
    port_in.r_ready = rr;
  end

  axi_mem_endpoint dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .s_axi_i (port_in),
    .s_axi_o (port_out)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // RREADY pattern: toggles each cycle when r_toggle is set, else held high.
  always @(posedge ACLK) begin
    #1;
    rr = r_toggle ? ~rr : 1'b1;
  end

  // Monitor: compare on handshakes, check stability under backpressure.
  logic        b_hold = 1'b0;
  logic [5:0]  b_saved;
  logic        r_hold = 1'b0;
  logic [38:0] r_saved;
  b_exp_t      be;
  r_exp_t      re;

  always @(negedge ACLK) begin
    if (ARESETn !== 1'b1) begin
      b_hold = 1'b0;
      r_hold = 1'b0;
    end else begin
      if (b_hold)
        check("b_stable", 64'({port_out.b_valid, port_out.b_id, port_out.b_resp}), 64'({1'b1, b_saved}));
      b_hold = 1'b0;
      if (port_out.b_valid) begin
        check("aw_ready_during_b", 64'(port_out.aw_ready), 64'(0));
        if (port_in.b_ready) begin
          if (b_q.size() == 0) begin
            timeout("b_unexpected");
          end else begin
            be = b_q.pop_front();
            check("b_id", 64'(port_out.b_id), 64'(be.id));
            check("b_resp", 64'(port_out.b_resp), 64'(be.resp));
          end
        end else begin
          b_hold  = 1'b1;
          b_saved = {port_out.b_id, port_out.b_resp};
        end
      end

      if (r_hold)
        check("r_stable", 64'({port_out.r_valid, port_out.r_id, port_out.r_data, port_out.r_resp, port_out.r_last}),
              64'({1'b1, r_saved}));
      r_hold = 1'b0;
      if (port_out.r_valid) begin
        if (port_in.r_ready) begin
          if (r_q.size() == 0) begin
            timeout("r_unexpected");
          end else begin
            re = r_q.pop_front();
            check("r_id", 64'(port_out.r_id), 64'(re.id));
            check("r_data", 64'(port_out.r_data), 64'(re.data));
            check("r_resp", 64'(port_out.r_resp), 64'(re.resp));
            check("r_last", 64'(port_out.r_last), 64'(re.last));
          end
        end else begin
          r_hold  = 1'b1;
          r_saved = {port_out.r_id, port_out.r_data, port_out.r_resp, port_out.r_last};
        end
      end
    end
  end

  task automatic send_aw(input logic [15:0] addr, input logic [7:0] len, input logic [3:0] id);
    int n = 0;
    drv.aw_addr  = addr;
    drv.aw_len   = len;
    drv.aw_id    = id;
    drv.aw_valid = 1'b1;
    @(negedge ACLK);
    while (!port_out.aw_ready && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    if (!port_out.aw_ready) timeout("aw_handshake");
    @(posedge ACLK);
    #1 drv.aw_valid = 1'b0;
  endtask

  task automatic send_ar(input logic [15:0] addr, input logic [7:0] len, input logic [3:0] id);
    int n = 0;
    drv.ar_addr  = addr;
    drv.ar_len   = len;
    drv.ar_id    = id;
    drv.ar_valid = 1'b1;
    @(negedge ACLK);
    while (!port_out.ar_ready && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    if (!port_out.ar_ready) timeout("ar_handshake");
    @(posedge ACLK);
    #1 drv.ar_valid = 1'b0;
  endtask

  // Issues AW then one W beat per data word; WLAST is set on the last word given.
  task automatic write_burst(input logic [15:0] addr, input logic [7:0] len, input logic [3:0] id,
                             input logic [31:0] d[$], input logic [3:0] strb, input logic [1:0] exp_resp);
    b_q.push_back('{id: id, resp: exp_resp});
    send_aw(addr, len, id);
    for (int i = 0; i < d.size(); i++) begin
      int n = 0;
      drv.w_data  = d[i];
      drv.w_strb  = strb;
      drv.w_last  = (i == d.size() - 1);
      drv.w_valid = 1'b1;
      @(negedge ACLK);
      while (!port_out.w_ready && n < 50) begin
        @(negedge ACLK);
        n++;
      end
      if (!port_out.w_ready) timeout("w_handshake");
      @(posedge ACLK);
      #1 drv.w_valid = 1'b0;
    end
  endtask

  task automatic read_burst(input logic [15:0] addr, input logic [7:0] len, input logic [3:0] id,
                            input logic [31:0] d[$], input logic [1:0] resp[$]);
    for (int i = 0; i < d.size(); i++)
      r_q.push_back('{id: id, data: d[i], resp: resp[i], last: (i == d.size() - 1)});
    send_ar(addr, len, id);
  endtask

  task automatic drain();
    int n = 0;
    while ((b_q.size() != 0 || r_q.size() != 0) && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    if (b_q.size() != 0 || r_q.size() != 0) begin
      timeout("response_drain");
      b_q.delete();
      r_q.delete();
    end
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    drv         = '0;
    drv.b_ready = 1'b1;
    ARESETn     = 1'b0;

    // 1: reset held with AWVALID/ARVALID asserted
    drv.aw_valid = 1'b1;
    drv.ar_valid = 1'b1;
    repeat (3) begin
      @(negedge ACLK);
      check("rst_aw_ready", 64'(port_out.aw_ready), 64'(0));
      check("rst_w_ready", 64'(port_out.w_ready), 64'(0));
      check("rst_ar_ready", 64'(port_out.ar_ready), 64'(0));
      check("rst_b_valid", 64'(port_out.b_valid), 64'(0));
      check("rst_r_valid", 64'(port_out.r_valid), 64'(0));
      check("rst_r_payload", 64'({port_out.r_last, port_out.r_data, port_out.r_resp, port_out.b_resp}), 64'(0));
    end
    @(posedge ACLK);
    #1;
    drv.aw_valid = 1'b0;
    drv.ar_valid = 1'b0;
    ARESETn      = 1'b1;
    @(negedge ACLK);
    check("idle_aw_ready", 64'(port_out.aw_ready), 64'(1));
    check("idle_ar_ready", 64'(port_out.ar_ready), 64'(1));
    @(posedge ACLK);
    #1;

    // 2: four-beat write then read back
    write_burst(16'h0010, 8'd3, 4'h1, '{32'h11, 32'h22, 32'h33, 32'h44}, 4'hF, 2'b00);
    drain();
    read_burst(16'h0010, 8'd3, 4'h5, '{32'h11, 32'h22, 32'h33, 32'h44}, '{2'b00, 2'b00, 2'b00, 2'b00});
    drain();

    // 3: partial strobe merge
    write_burst(16'h0000, 8'd0, 4'h2, '{32'hAABBCCDD}, 4'hF, 2'b00);
    drain();
    write_burst(16'h0000, 8'd0, 4'h3, '{32'h11223344}, 4'b0101, 2'b00);
    drain();
    read_burst(16'h0000, 8'd0, 4'h6, '{32'hAA22CC44}, '{2'b00});
    drain();

    // 4: burst crossing the end of the array
    write_burst(16'h03FC, 8'd1, 4'h4, '{32'hDEADBEEF, 32'hCAFEF00D}, 4'hF, 2'b10);
    drain();
    read_burst(16'h03FC, 8'd1, 4'h7, '{32'hDEADBEEF, 32'h0}, '{2'b00, 2'b10});
    drain();

    // 5: B backpressure for 5 cycles, then R with toggling RREADY
    drv.b_ready = 1'b0;
    write_burst(16'h0020, 8'd0, 4'h9, '{32'h55}, 4'hF, 2'b00);
    repeat (5) @(posedge ACLK);
    #1 drv.b_ready = 1'b1;
    drain();
    r_toggle = 1'b1;
    read_burst(16'h0010, 8'd4, 4'hA, '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55},
               '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
    drain();
    r_toggle = 1'b0;
    @(posedge ACLK);
    #1;

    // 6: early WLAST on beat 1 of a 4-beat burst, then a normal burst
    write_burst(16'h0040, 8'd3, 4'hC, '{32'h77777777, 32'h88888888}, 4'hF, 2'b10);
    drain();
    write_burst(16'h0044, 8'd0, 4'hD, '{32'h99}, 4'hF, 2'b00);
    drain();
    read_burst(16'h0040, 8'd1, 4'hE, '{32'h77777777, 32'h99}, '{2'b00, 2'b00});
    drain();

    repeat (2) @(posedge ACLK);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
